md_sched: RTL and testbench

MD_SCHED -- requirements
Module: md_sched

---
 rtl/md_sched_if.sv | 22 ++
 rtl/md_sched.sv | 146 ++++++++++++++
 tb/tb_md_sched.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/md_sched_if.sv
// HI/LO multiply-divide scheduler bus: EX-stage issue, ID-stage hazard query, results.
interface md_sched_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        md_use_ID;
  logic        busy;
  logic        stall_md;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, a, b, md_use_ID,
    input  busy, stall_md, hi, lo
  );

  modport slave (
    input  start, op, a, b, md_use_ID,
    output busy, stall_md, hi, lo
  );
endinterface

// File: rtl/md_sched.sv
// Multi-cycle HI/LO unit: mult/multu/div/divu with fixed latency, mthi/mtlo, pipeline stall request.
module md_sched #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  md_sched_if.slave   bus
);

  localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [1:0]         op_q;
  logic [31:0]        a_q;
  logic [31:0]        b_q;

  logic               load;
  logic               mt_hi;
  logic               mt_lo;
  logic               done;

  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic               div_zero;
  logic               div_ovf;
  logic [31:0]        div_b_s;
  logic [31:0]        div_b_u;
  logic [31:0]        quo_s;
  logic [31:0]        rem_s;
  logic [31:0]        quo_u;
  logic [31:0]        rem_u;
  logic               res_we;
  logic [31:0]        res_hi;
  logic [31:0]        res_lo;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state: accept a multi-cycle op in IDLE, leave RUN on the last count
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load) state_nxt = RUN;
      RUN:     if (cnt == CNT_W'(1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs and strobes decoded from the current state and issue inputs
  always_comb begin
    bus.busy     = 1'b0;
    load         = 1'b0;
    mt_hi        = 1'b0;
    mt_lo        = 1'b0;
    done         = 1'b0;
    case (state)
      IDLE: begin
        load  = bus.start && (bus.op <= 3'd3);
        mt_hi = bus.start && (bus.op == 3'd4);
        mt_lo = bus.start && (bus.op == 3'd5);
      end
      RUN: begin
        bus.busy = 1'b1;
        done     = (cnt == CNT_W'(1));
      end
      default: ;
    endcase
    bus.stall_md = bus.md_use_ID && (bus.busy || (bus.start && (bus.op <= 3'd3)));
  end

  // Arithmetic on latched operands; divisors forced to 1 where the quotient is undefined or overflows
  assign prod_s   = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
  assign prod_u   = {32'd0, a_q} * {32'd0, b_q};
  assign div_zero = (b_q == 32'd0);
  assign div_ovf  = (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
  assign div_b_s  = (div_zero || div_ovf) ? 32'd1 : b_q;
  assign div_b_u  = div_zero ? 32'd1 : b_q;
  assign quo_s    = 32'($signed(a_q) / $signed(div_b_s));
  assign rem_s    = 32'($signed(a_q) % $signed(div_b_s));
  assign quo_u    = a_q / div_b_u;
  assign rem_u    = a_q % div_b_u;

  // Result select by latched op; division by zero suppresses the write-back
  always_comb begin
    res_we = 1'b0;
    res_hi = '0;
    res_lo = '0;
    case (op_q)
      2'd0: begin
        {res_hi, res_lo} = prod_s;
        res_we = 1'b1;
      end
      2'd1: begin
        {res_hi, res_lo} = prod_u;
        res_we = 1'b1;
      end
      2'd2: begin
        res_hi = rem_s;
        res_lo = quo_s;
        res_we = !div_zero;
      end
      default: begin
        res_hi = rem_u;
        res_lo = quo_u;
        res_we = !div_zero;
      end
    endcase
  end

  // Operand latch, latency counter and architectural HI/LO
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      bus.hi <= '0;
      bus.lo <= '0;
    end else begin
      if (load) begin
        a_q  <= bus.a;
        b_q  <= bus.b;
        op_q <= bus.op[1:0];
        cnt  <= bus.op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      end else if (state == RUN) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (mt_hi) bus.hi <= bus.a;
      if (mt_lo) bus.lo <= bus.a;
      if (done && res_we) begin
        bus.hi <= res_hi;
        bus.lo <= res_lo;
      end
    end
  end

endmodule

// File: tb/tb_md_sched.sv
// Directed bench for md_sched: vector table of arithmetic ops plus hand-written corner sequences.
module tb_md_sched;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  md_sched_if mdif ();

  md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (mdif.slave)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    bit          keep;
    logic [31:0] eh;
    logic [31:0] el;
    int          ncyc;
  } vec_t;

  vec_t        vecs [10];
  int          n_pass  = 0;
  int          n_total = 0;
  logic [31:0] mdl_hi  = 32'd0;
  logic [31:0] mdl_lo  = 32'd0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Issue one op at a negedge and follow it to completion; optional stray starts mid-run
  task automatic run_op(input string nm, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic use_id, input logic [31:0] eh,
                        input logic [31:0] el, input int ncyc, input bit inject);
    int n;
    mdif.md_use_ID = use_id;
    mdif.op        = op;
    mdif.a         = a;
    mdif.b         = b;
    mdif.start     = 1'b1;
    #1;
    check({nm, " stall_start"}, 32'(mdif.stall_md), 32'(use_id));
    @(posedge clk);
    @(negedge clk);
    mdif.start = 1'b0;
    mdif.a     = $urandom;
    mdif.b     = $urandom;
    n = 0;
    while (mdif.busy === 1'b1 && n < 40) begin
      check({nm, " stall_busy"}, 32'(mdif.stall_md), 32'(use_id));
      if (inject && n == 2) begin
        mdif.start = 1'b1; mdif.op = 3'd4; mdif.a = 32'h0000_1234;
      end else if (inject && n == 4) begin
        mdif.start = 1'b1; mdif.op = 3'd0; mdif.a = 32'd9; mdif.b = 32'd9;
      end else begin
        mdif.start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    mdif.start = 1'b0;
    #1;
    check({nm, " busy_cycles"}, 32'(n), 32'(ncyc));
    check({nm, " stall_after"}, 32'(mdif.stall_md), 32'd0);
    check({nm, " hi"}, mdif.hi, eh);
    check({nm, " lo"}, mdif.lo, el);
    mdl_hi = eh;
    mdl_lo = el;
  endtask

  initial begin
    vecs[0] = '{3'd0, 32'hFFFF_FFFE, 32'd3,        1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
    vecs[1] = '{3'd1, 32'hFFFF_FFFE, 32'd3,        1'b0, 32'h0000_0002, 32'hFFFF_FFFA, 5};
    vecs[2] = '{3'd2, 32'hFFFF_FFF9, 32'd2,        1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
    vecs[3] = '{3'd3, 32'd7,         32'd0,        1'b1, 32'd0,         32'd0,         10};
    vecs[4] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 32'h8000_0000, 10};
    vecs[5] = '{3'd3, 32'd100,       32'd7,        1'b0, 32'd2,         32'd14,        10};
    vecs[6] = '{3'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 32'h3FFF_FFFF, 32'h0000_0001, 5};
    vecs[7] = '{3'd2, 32'd7,         32'hFFFF_FFFE, 1'b0, 32'h0000_0001, 32'hFFFF_FFFD, 10};
    vecs[8] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001, 5};
    vecs[9] = '{3'd2, 32'h8000_0000, 32'd0,        1'b1, 32'd0,         32'd0,         10};

    reset          = 1'b1;
    mdif.start     = 1'b0;
    mdif.op        = 3'd0;
    mdif.a         = 32'd0;
    mdif.b         = 32'd0;
    mdif.md_use_ID = 1'b0;
    repeat (2) @(negedge clk);
    check("reset busy", 32'(mdif.busy), 32'd0);
    check("reset stall", 32'(mdif.stall_md), 32'd0);
    check("reset hi", mdif.hi, 32'd0);
    check("reset lo", mdif.lo, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Arithmetic vector table, stall requested throughout
    for (int i = 0; i < 10; i++) begin
      logic [31:0] eh;
      logic [31:0] el;
      eh = vecs[i].keep ? mdl_hi : vecs[i].eh;
      el = vecs[i].keep ? mdl_lo : vecs[i].el;
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, 1'b1,
             eh, el, vecs[i].ncyc, 1'b0);
    end

    // mtlo then mthi in IDLE: single-edge write, no RUN
    mdif.md_use_ID = 1'b1;
    mdif.op = 3'd5; mdif.a = 32'hDEAD_BEEF; mdif.start = 1'b1;
    #1;
    check("mtlo stall", 32'(mdif.stall_md), 32'd0);
    @(posedge clk); @(negedge clk);
    mdif.start = 1'b0;
    #1;
    check("mtlo lo", mdif.lo, 32'hDEAD_BEEF);
    check("mtlo hi", mdif.hi, mdl_hi);
    check("mtlo busy", 32'(mdif.busy), 32'd0);
    mdl_lo = 32'hDEAD_BEEF;
    mdif.op = 3'd4; mdif.a = 32'hCAFE_F00D; mdif.start = 1'b1;
    @(posedge clk); @(negedge clk);
    mdif.start = 1'b0;
    #1;
    check("mthi hi", mdif.hi, 32'hCAFE_F00D);
    check("mthi lo", mdif.lo, 32'hDEAD_BEEF);
    check("mthi busy", 32'(mdif.busy), 32'd0);
    mdl_hi = 32'hCAFE_F00D;

    // ops 6 and 7 do nothing
    for (int k = 6; k < 8; k++) begin
      mdif.op = 3'(k); mdif.a = 32'h5555_5555; mdif.b = 32'd3; mdif.start = 1'b1;
      #1;
      check($sformatf("nop%0d stall", k), 32'(mdif.stall_md), 32'd0);
      @(posedge clk); @(negedge clk);
      mdif.start = 1'b0;
      #1;
      check($sformatf("nop%0d busy", k), 32'(mdif.busy), 32'd0);
      check($sformatf("nop%0d hi", k), mdif.hi, mdl_hi);
      check($sformatf("nop%0d lo", k), mdif.lo, mdl_lo);
      @(negedge clk);
    end

    // mult without ID-stage use: never stalls
    run_op("mult_noid", 3'd0, 32'd6, 32'd7, 1'b0, 32'd0, 32'd42, 5, 1'b0);

    // div with stray mthi and mult starts mid-run: both ignored
    run_op("div_ignore", 3'd2, 32'd100, 32'hFFFF_FFFD, 1'b1, 32'd1, 32'hFFFF_FFDF, 10, 1'b1);

    // Reset in the third cycle of a mult: immediate clear, no late write-back
    mdif.md_use_ID = 1'b1;
    mdif.op = 3'd0; mdif.a = 32'd5; mdif.b = 32'd5; mdif.start = 1'b1;
    @(posedge clk); @(negedge clk);
    mdif.start = 1'b0;
    @(posedge clk); @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("rst_mid busy", 32'(mdif.busy), 32'd0);
    check("rst_mid stall", 32'(mdif.stall_md), 32'd0);
    check("rst_mid hi", mdif.hi, 32'd0);
    check("rst_mid lo", mdif.lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    check("rst_after busy", 32'(mdif.busy), 32'd0);
    check("rst_after hi", mdif.hi, 32'd0);
    check("rst_after lo", mdif.lo, 32'd0);

    // Reset release with start on the very next edge
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    run_op("post_rst_mult", 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'd1, 5, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
